// File: rtl/prs_checker.sv
// Receive-side checker for the 4-stage XNOR PRS generator.
// Self-synchronises a local LFSR copy from the incoming stream, declares lock,
// then counts checked bits and bit errors, dropping lock on an error burst.
module prs_checker #(
    parameter int unsigned SYNC_LEN  = 8,
    parameter int unsigned LOSS_ERRS = 4,
    parameter int unsigned WINDOW    = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic             sync_lost,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned RUN_W  = $clog2(SYNC_LEN + 1);
    localparam int unsigned WERR_W = $clog2(LOSS_ERRS + 1);
    localparam int unsigned WPOS_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    typedef enum logic [1:0] {
        ST_FILL   = 2'b00,
        ST_HUNT   = 2'b01,
        ST_LOCKED = 2'b10
    } state_e;

    state_e              state_q, state_nxt;
    logic [3:0]          hist, hist_nxt;
    logic [1:0]          fill_cnt, fill_nxt;
    logic [RUN_W-1:0]    run, run_nxt, run_inc;
    logic [WPOS_W-1:0]   win_pos, win_pos_nxt;
    logic [WERR_W-1:0]   win_err, win_err_nxt, win_err_inc;
    logic [CNT_W-1:0]    bit_cnt_nxt, err_cnt_nxt;
    logic                err_pulse_nxt, sync_lost_nxt;
    logic                exp_bit, mismatch, loss;

    // Prediction from the history before the shift; all-ones is the LFSR lockup
    // state and is always treated as an error so a stuck-at-1 line never locks.
    assign exp_bit     = ~(hist[2] ^ hist[3]);
    assign mismatch    = (din != exp_bit) || (hist == 4'hF);
    assign run_inc     = run + RUN_W'(1);
    assign win_err_inc = win_err + WERR_W'(1);
    assign state       = state_q;

    // Next-state, window, counter and flag logic.
    always_comb begin
        state_nxt     = state_q;
        hist_nxt      = hist;
        fill_nxt      = fill_cnt;
        run_nxt       = run;
        win_pos_nxt   = win_pos;
        win_err_nxt   = win_err;
        bit_cnt_nxt   = bit_cnt;
        err_cnt_nxt   = err_cnt;
        err_pulse_nxt = 1'b0;
        sync_lost_nxt = sync_lost;
        loss          = 1'b0;

        if (din_valid) begin
            hist_nxt = {hist[2:0], din};
            case (state_q)
                ST_FILL: begin
                    fill_nxt = fill_cnt + 2'd1;
                    if (fill_cnt == 2'd3) begin
                        state_nxt = ST_HUNT;
                        run_nxt   = '0;
                    end
                end
                ST_HUNT: begin
                    if (mismatch) begin
                        run_nxt = '0;
                    end else if (run_inc == RUN_W'(SYNC_LEN)) begin
                        state_nxt   = ST_LOCKED;
                        run_nxt     = '0;
                        win_pos_nxt = '0;
                        win_err_nxt = '0;
                    end else begin
                        run_nxt = run_inc;
                    end
                end
                ST_LOCKED: begin
                    if (bit_cnt != '1) bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    if (mismatch) begin
                        err_pulse_nxt = 1'b1;
                        if (err_cnt != '1) err_cnt_nxt = err_cnt + CNT_W'(1);
                    end
                    // Loss is checked before the wrap so an error on the last
                    // window bit still counts toward dropping lock.
                    if (mismatch && (win_err_inc == WERR_W'(LOSS_ERRS))) begin
                        loss          = 1'b1;
                        state_nxt     = ST_HUNT;
                        run_nxt       = '0;
                        sync_lost_nxt = 1'b1;
                    end else if (win_pos == WPOS_W'(WINDOW - 1)) begin
                        win_pos_nxt = '0;
                        win_err_nxt = '0;
                    end else begin
                        win_pos_nxt = win_pos + WPOS_W'(1);
                        if (mismatch) win_err_nxt = win_err_inc;
                    end
                end
                default: begin
                    state_nxt = ST_FILL;
                    fill_nxt  = '0;
                end
            endcase
        end

        // Clear only touches the statistics; a concurrent loss keeps sync_lost set.
        if (clear) begin
            bit_cnt_nxt = '0;
            err_cnt_nxt = '0;
            if (!loss) sync_lost_nxt = 1'b0;
        end
    end

    // State, history, window and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_FILL;
            hist      <= '0;
            fill_cnt  <= '0;
            run       <= '0;
            win_pos   <= '0;
            win_err   <= '0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
            err_pulse <= 1'b0;
            sync_lost <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            hist      <= hist_nxt;
            fill_cnt  <= fill_nxt;
            run       <= run_nxt;
            win_pos   <= win_pos_nxt;
            win_err   <= win_err_nxt;
            bit_cnt   <= bit_cnt_nxt;
            err_cnt   <= err_cnt_nxt;
            err_pulse <= err_pulse_nxt;
            sync_lost <= sync_lost_nxt;
            locked    <= (state_nxt == ST_LOCKED);
        end
    end

endmodule

// File: tb/tb_prs_checker.sv
// Bench for prs_checker: reference model feeds a scoreboard queue per driven bit,
// plus directed checks on the lock/loss/clear/reset scenarios.
module tb_prs_checker;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST_N, din_valid, din, clear;
    logic        locked, err_pulse, sync_lost;
    logic [1:0]  state;
    logic [15:0] bit_cnt, err_cnt;
    logic        s_locked, s_err_pulse, s_sync_lost;
    logic [1:0]  s_state;
    logic [3:0]  s_bit_cnt, s_err_cnt;

    prs_checker u_dut (
        .CLK(CLK), .RST_N(RST_N), .din_valid(din_valid), .din(din), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .sync_lost(sync_lost),
        .state(state), .bit_cnt(bit_cnt), .err_cnt(err_cnt)
    );

    prs_checker #(.CNT_W(4)) u_sat (
        .CLK(CLK), .RST_N(RST_N), .din_valid(din_valid), .din(din), .clear(clear),
        .locked(s_locked), .err_pulse(s_err_pulse), .sync_lost(s_sync_lost),
        .state(s_state), .bit_cnt(s_bit_cnt), .err_cnt(s_err_cnt)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        lk;
        logic        ep;
        logic        sl;
        logic [15:0] bc;
        logic [15:0] ec;
        logic [3:0]  sbc;
        logic [3:0]  sec;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Generator copy and reference model state.
    logic [3:0] g;
    logic [3:0] m_h;
    int m_st, m_fill, m_run, m_wpos, m_werr, m_bc, m_ec;
    bit m_ep, m_sl;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_h = 4'h0; m_st = 0; m_fill = 0; m_run = 0; m_wpos = 0; m_werr = 0;
        m_bc = 0; m_ec = 0; m_ep = 0; m_sl = 0; g = 4'h0;
    endtask

    task automatic model_step(input bit v, input bit d, input bit clr);
        bit expb, mis, loss;
        loss = 0;
        m_ep = 0;
        if (v) begin
            expb = !(m_h[2] ^ m_h[3]);
            mis  = (d != expb) || (m_h == 4'hF);
            if (m_st == 0) begin
                m_fill++;
                if (m_fill == 4) begin m_st = 1; m_run = 0; end
            end else if (m_st == 1) begin
                if (mis) m_run = 0; else m_run++;
                if (m_run == 8) begin m_st = 2; m_run = 0; m_wpos = 0; m_werr = 0; end
            end else begin
                m_bc++;
                if (mis) begin m_ep = 1; m_ec++; m_werr++; end
                if (mis && m_werr == 4) begin
                    loss = 1; m_st = 1; m_run = 0; m_sl = 1;
                end else if (m_wpos == 15) begin
                    m_wpos = 0; m_werr = 0;
                end else begin
                    m_wpos++;
                end
            end
            m_h = {m_h[2:0], d};
        end
        if (clr) begin
            m_bc = 0; m_ec = 0;
            if (!loss) m_sl = 0;
        end
    endtask

    // Drive one cycle, push the model's expectation, pop and compare after the edge.
    task automatic step(input bit v, input bit d, input bit clr);
        exp_t e;
        din_valid = v; din = d; clear = clr;
        model_step(v, d, clr);
        e.st  = 2'(m_st);
        e.lk  = (m_st == 2);
        e.ep  = m_ep;
        e.sl  = m_sl;
        e.bc  = 16'(sat(m_bc, 65535));
        e.ec  = 16'(sat(m_ec, 65535));
        e.sbc = 4'(sat(m_bc, 15));
        e.sec = 4'(sat(m_ec, 15));
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'(0), 32'(1));
        end else begin
            e = sb_q.pop_front();
            chk("sb_state",   32'(state),     32'(e.st));
            chk("sb_locked",  32'(locked),    32'(e.lk));
            chk("sb_pulse",   32'(err_pulse), 32'(e.ep));
            chk("sb_lost",    32'(sync_lost), 32'(e.sl));
            chk("sb_bitcnt",  32'(bit_cnt),   32'(e.bc));
            chk("sb_errcnt",  32'(err_cnt),   32'(e.ec));
            chk("sb_slocked", 32'(s_locked),  32'(e.lk));
            chk("sb_sbitcnt", 32'(s_bit_cnt), 32'(e.sbc));
            chk("sb_serrcnt", 32'(s_err_cnt), 32'(e.sec));
        end
        din_valid = 0; clear = 0;
    endtask

    // Next generator bit, optionally inverted on the line.
    task automatic gen_step(input bit inv, input bit clr);
        logic b;
        b = ~(g[2] ^ g[3]);
        g = {g[2:0], b};
        step(1'b1, b ^ inv, clr);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_state"},  32'(state),     32'(0));
        chk({tag, "_locked"}, 32'(locked),    32'(0));
        chk({tag, "_pulse"},  32'(err_pulse), 32'(0));
        chk({tag, "_lost"},   32'(sync_lost), 32'(0));
        chk({tag, "_bits"},   32'(bit_cnt),   32'(0));
        chk({tag, "_errs"},   32'(err_cnt),   32'(0));
    endtask

    task automatic hard_reset();
        RST_N = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        chk_zero("rst");
        RST_N = 1'b1;
    endtask

    initial begin
        int k;
        int nv;
        bit seen;
        RST_N = 1'b0; din_valid = 0; din = 0; clear = 0;
        model_reset();
        #12;
        chk_zero("por");
        RST_N = 1'b1;

        // 1: acquire lock from the generator's reset state.
        for (int i = 1; i <= 12; i++) begin
            gen_step(1'b0, 1'b0);
            if (i <= 3)  chk("t1_fill",   32'(state),  32'(0));
            if (i == 4)  chk("t1_hunt",   32'(state),  32'(1));
            if (i == 11) chk("t1_nolock", 32'(locked), 32'(0));
            if (i == 12) begin
                chk("t1_lock", 32'(locked),  32'(1));
                chk("t1_errs", 32'(err_cnt), 32'(0));
            end
        end

        // 2: one inverted bit, then 100 clean bits.
        gen_step(1'b1, 1'b0);
        chk("t2_pulse", 32'(err_pulse), 32'(1));
        chk("t2_err1",  32'(err_cnt),   32'(1));
        for (int i = 0; i < 100; i++) gen_step(1'b0, 1'b0);
        chk("t2_bits",   32'(bit_cnt),   32'(101));
        chk("t2_locked", 32'(locked),    32'(1));
        chk("t2_sat",    32'(s_bit_cnt), 32'(15));
        // The corrupted bit re-appears in the history as taps 3 and 4.
        chk("t2_errs",   32'(err_cnt),   32'(3));

        // 3: four inverted bits within a window drop lock, then relock.
        for (int i = 0; i < 12; i++) gen_step((i < 8) && (i % 2 == 0), 1'b0);
        chk("t3_unlock", 32'(locked),    32'(0));
        chk("t3_lost",   32'(sync_lost), 32'(1));
        k = 0;
        while (!locked && k < 40) begin
            gen_step(1'b0, 1'b0);
            k++;
        end
        chk("t3_relock",      32'(locked), 32'(1));
        chk("t3_relock_bits", 32'(k),      32'(7));

        // 5: clear together with an error bit.
        gen_step(1'b1, 1'b1);
        chk("t5_bits",  32'(bit_cnt),   32'(0));
        chk("t5_errs",  32'(err_cnt),   32'(0));
        chk("t5_pulse", 32'(err_pulse), 32'(1));
        chk("t5_lost",  32'(sync_lost), 32'(0));
        for (int i = 0; i < 6; i++) gen_step(1'b0, 1'b0);

        // 6: async reset while locked, then a gapped stream.
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        chk_zero("t6_async");
        @(posedge CLK);
        #1;
        chk_zero("t6_hold");
        RST_N = 1'b1;
        nv = 0;
        k = 0;
        while (nv < 40 && k < 400) begin
            if ($urandom_range(0, 1) == 1) begin
                gen_step(1'b0, 1'b0);
                nv++;
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            k++;
        end
        chk("t6_valid_bits", 32'(nv),        32'(40));
        chk("t6_locked",     32'(locked),    32'(1));
        chk("t6_sat_bits",   32'(s_bit_cnt), 32'(15));

        // 4: stuck-at-1 and stuck-at-0 never lock.
        hard_reset();
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (locked) seen = 1;
        end
        chk("t4_ones_lock",  32'(seen),  32'(0));
        chk("t4_ones_state", 32'(state), 32'(1));
        hard_reset();
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (locked) seen = 1;
        end
        chk("t4_zeros_lock",  32'(seen),  32'(0));
        chk("t4_zeros_state", 32'(state), 32'(1));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
